// File: rtl/lc3_control_seq_if.sv
// Handshake and control bus between the LC-3 sequencer and the datapath/memory side.
interface lc3_control_seq_if;
  logic        complete_instr;
  logic        complete_data;
  logic [15:0] IR;
  logic [2:0]  psr;
  logic [15:0] pcout;
  logic        enable_fetch;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  logic        enable_updatePC;
  logic        br_taken;
  logic [15:0] taddr;
  logic [1:0]  mem_state;
  logic [15:0] instr_count;

  modport master (
    input  complete_instr, complete_data, IR, psr, pcout,
    output enable_fetch, enable_decode, enable_execute, enable_writeback,
           enable_updatePC, br_taken, taddr, mem_state, instr_count
  );

  modport slave (
    output complete_instr, complete_data, IR, psr, pcout,
    input  enable_fetch, enable_decode, enable_execute, enable_writeback,
           enable_updatePC, br_taken, taddr, mem_state, instr_count
  );
endinterface

// File: rtl/lc3_control_seq.sv
// Multi-cycle LC-3 control sequencer: one-hot stage enables, memory mode, branch decision,
// target latch and retired-instruction counter.
module lc3_control_seq #(
  parameter logic [1:0] MEM_IDLE = 2'b11
) (
  input  logic              clock,
  input  logic              reset,
  lc3_control_seq_if.master bus
);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXECUTE, MEM_IND, MEM, WB, UPDPC
  } state_t;

  state_t      state, state_next;
  logic [15:0] taddr, instr_count;
  logic [3:0]  opcode;
  logic [2:0]  nzp;
  logic        is_store;
  logic        unused_ir;

  assign opcode    = bus.IR[15:12];
  assign nzp       = bus.IR[11:9];
  assign unused_ir = ^bus.IR[8:0];
  // STI reaches MEM through MEM_IND, so it is classified here with the direct stores.
  assign is_store  = (opcode == 4'b0011) || (opcode == 4'b0111) || (opcode == 4'b1011);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= FETCH;
      taddr       <= 16'h0000;
      instr_count <= 16'h0000;
    end else begin
      state <= state_next;
      if (state == EXECUTE) taddr <= bus.pcout;
      if (state == UPDPC) instr_count <= instr_count + 16'd1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:   if (bus.complete_instr) state_next = DECODE;
      DECODE:  state_next = EXECUTE;
      EXECUTE: begin
        case (opcode)
          4'b0001, 4'b0101, 4'b1001, 4'b1110: state_next = WB;
          4'b0010, 4'b0110, 4'b0011, 4'b0111: state_next = MEM;
          4'b1010, 4'b1011:                   state_next = MEM_IND;
          default:                            state_next = UPDPC;
        endcase
      end
      MEM_IND: if (bus.complete_data) state_next = MEM;
      MEM:     if (bus.complete_data) state_next = is_store ? UPDPC : WB;
      WB:      state_next = UPDPC;
      UPDPC:   state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // Outputs are forced idle while reset is held, whatever state the register still shows.
  always_comb begin
    bus.enable_fetch     = 1'b0;
    bus.enable_decode    = 1'b0;
    bus.enable_execute   = 1'b0;
    bus.enable_writeback = 1'b0;
    bus.enable_updatePC  = 1'b0;
    bus.br_taken         = 1'b0;
    bus.mem_state        = MEM_IDLE;
    if (!reset) begin
      case (state)
        FETCH:   bus.enable_fetch     = 1'b1;
        DECODE:  bus.enable_decode    = 1'b1;
        EXECUTE: bus.enable_execute   = 1'b1;
        MEM_IND: bus.mem_state        = 2'b01;
        MEM:     bus.mem_state        = is_store ? 2'b10 : 2'b00;
        WB:      bus.enable_writeback = 1'b1;
        UPDPC: begin
          bus.enable_updatePC = 1'b1;
          case (opcode)
            4'b1100: bus.br_taken = 1'b1;
            4'b0000: bus.br_taken = |(nzp & bus.psr);
            default: bus.br_taken = 1'b0;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.taddr       = taddr;
  assign bus.instr_count = instr_count;

endmodule

// File: tb/tb_lc3_control_seq.sv
// Directed bench for lc3_control_seq: instruction flows, memory waits, reset abort and counter wrap.
module tb_lc3_control_seq;
  logic clock = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  lc3_control_seq_if bus ();

  lc3_control_seq #(.MEM_IDLE(2'b11)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  localparam logic [4:0] E_F = 5'b10000, E_D = 5'b01000, E_E = 5'b00100,
                         E_W = 5'b00010, E_U = 5'b00001, E_0 = 5'b00000;

  function automatic logic [4:0] en();
    return {bus.enable_fetch, bus.enable_decode, bus.enable_execute,
            bus.enable_writeback, bus.enable_updatePC};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.complete_instr = 1'b0;
    bus.complete_data  = 1'b0;
    bus.IR    = 16'h0000;
    bus.psr   = 3'b000;
    bus.pcout = 16'h0000;
    step();
    step();
    chk("rst_en", {27'd0, en()}, {27'd0, E_0});
    chk("rst_mem", {30'd0, bus.mem_state}, 32'h3);
    chk("rst_br", {31'd0, bus.br_taken}, 32'h0);
    chk("rst_taddr", {16'd0, bus.taddr}, 32'h0);
    chk("rst_cnt", {16'd0, bus.instr_count}, 32'h0);

    // ADD: five-cycle instruction
    reset = 1'b0;
    bus.IR = 16'h1042;
    bus.pcout = 16'h1234;
    bus.complete_instr = 1'b1;
    #1;
    chk("add_fetch", {27'd0, en()}, {27'd0, E_F});
    step(); bus.complete_instr = 1'b0;
    chk("add_decode", {27'd0, en()}, {27'd0, E_D});
    step();
    chk("add_exec", {27'd0, en()}, {27'd0, E_E});
    step();
    chk("add_wb", {27'd0, en()}, {27'd0, E_W});
    chk("add_wb_mem", {30'd0, bus.mem_state}, 32'h3);
    step();
    chk("add_upd", {27'd0, en()}, {27'd0, E_U});
    chk("add_br", {31'd0, bus.br_taken}, 32'h0);
    step();
    chk("add_cnt", {16'd0, bus.instr_count}, 32'h1);
    chk("add_back", {27'd0, en()}, {27'd0, E_F});

    // BRz taken with Z set, then not taken with N set
    bus.IR = 16'h0405; bus.psr = 3'b010; bus.pcout = 16'h3010;
    bus.complete_instr = 1'b1;
    step(); bus.complete_instr = 1'b0;
    step();
    chk("brz_exec", {27'd0, en()}, {27'd0, E_E});
    step();
    chk("brz_upd", {27'd0, en()}, {27'd0, E_U});
    chk("brz_taddr", {16'd0, bus.taddr}, 32'h3010);
    chk("brz_br", {31'd0, bus.br_taken}, 32'h1);
    step();
    bus.psr = 3'b100; bus.pcout = 16'h4444;
    bus.complete_instr = 1'b1;
    step(); bus.complete_instr = 1'b0;
    chk("taddr_hold", {16'd0, bus.taddr}, 32'h3010);
    step(); step();
    chk("brn_upd", {27'd0, en()}, {27'd0, E_U});
    chk("brn_taddr", {16'd0, bus.taddr}, 32'h4444);
    chk("brn_br", {31'd0, bus.br_taken}, 32'h0);
    step();
    chk("br_cnt", {16'd0, bus.instr_count}, 32'h3);

    // LDI: three MEM_IND cycles then two MEM cycles
    bus.IR = 16'hA001;
    bus.complete_instr = 1'b1;
    step(); bus.complete_instr = 1'b0;
    step(); step();
    chk("ldi_ind1", {30'd0, bus.mem_state}, 32'h1);
    chk("ldi_ind1_en", {27'd0, en()}, {27'd0, E_0});
    step();
    chk("ldi_ind2", {30'd0, bus.mem_state}, 32'h1);
    bus.complete_instr = 1'b1;
    step();
    chk("ldi_ind3", {30'd0, bus.mem_state}, 32'h1);
    bus.complete_instr = 1'b0;
    bus.complete_data = 1'b1;
    step(); bus.complete_data = 1'b0;
    chk("ldi_mem1", {30'd0, bus.mem_state}, 32'h0);
    step();
    chk("ldi_mem2", {30'd0, bus.mem_state}, 32'h0);
    bus.complete_data = 1'b1;
    step(); bus.complete_data = 1'b0;
    chk("ldi_wb", {27'd0, en()}, {27'd0, E_W});
    chk("ldi_wb_mem", {30'd0, bus.mem_state}, 32'h3);
    step();
    chk("ldi_upd", {27'd0, en()}, {27'd0, E_U});
    step();
    chk("ldi_cnt", {16'd0, bus.instr_count}, 32'h4);

    // STR: store goes MEM -> UPDPC with no writeback
    bus.IR = 16'h7000;
    bus.complete_instr = 1'b1;
    step(); bus.complete_instr = 1'b0;
    step(); step();
    chk("str_mem", {30'd0, bus.mem_state}, 32'h2);
    bus.complete_data = 1'b1;
    step(); bus.complete_data = 1'b0;
    chk("str_upd", {27'd0, en()}, {27'd0, E_U});
    chk("str_upd_mem", {30'd0, bus.mem_state}, 32'h3);
    step();
    chk("str_cnt", {16'd0, bus.instr_count}, 32'h5);

    // Reset aborts a pending LD memory wait
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.IR = 16'h2000; bus.pcout = 16'h5555;
    bus.complete_instr = 1'b1;
    step(); bus.complete_instr = 1'b0;
    step(); step();
    chk("ld_mem", {30'd0, bus.mem_state}, 32'h0);
    step();
    reset = 1'b1;
    bus.complete_data = 1'b1;
    step();
    chk("abort_en", {27'd0, en()}, {27'd0, E_0});
    chk("abort_mem", {30'd0, bus.mem_state}, 32'h3);
    chk("abort_br", {31'd0, bus.br_taken}, 32'h0);
    chk("abort_taddr", {16'd0, bus.taddr}, 32'h0);
    chk("abort_cnt", {16'd0, bus.instr_count}, 32'h0);
    reset = 1'b0;
    bus.complete_data = 1'b0;
    #1;
    chk("abort_fetch", {27'd0, en()}, {27'd0, E_F});

    // Counter wrap: 65535 NOP retirements, then one more
    bus.IR = 16'hD000;
    bus.complete_instr = 1'b1;
    for (int i = 0; i < 65535 * 4; i++) step();
    chk("nop_cnt_ffff", {16'd0, bus.instr_count}, 32'hFFFF);
    chk("nop_fetch", {27'd0, en()}, {27'd0, E_F});
    step(); step();
    chk("nop_exec", {27'd0, en()}, {27'd0, E_E});
    step();
    chk("nop_br", {31'd0, bus.br_taken}, 32'h0);
    step();
    chk("nop_wrap", {16'd0, bus.instr_count}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
